// File: rtl/execute_unit_mc.sv
// execute_unit_mc: multicycle execute stage (ALU, shift-add MUL, restoring DIV, HI/LO) with start/busy/done handshake; ports clock, reset, start, op, operand_a/b, immediate, alu_src, shamt -> busy, done, result, zero, hi, lo
module execute_unit_mc #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] immediate,
  input  logic             alu_src,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] b, alu_y, abs_a, abs_b, mcand, acc, q, acc_n, q_n;
  logic [WIDTH-1:0] prod_hi, prod_lo, quot, rem, hi_f, lo_f;
  logic [WIDTH:0] sum, sh, trial;
  logic [SHW-1:0] count;
  logic sign_a, sign_b, div_zero, md, last;

  always_comb begin
    b = alu_src ? immediate : operand_b;
    md = op[3:2] == 2'b10;
    abs_a = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    abs_b = (op[0] && b[WIDTH-1]) ? -b : b;
    last = count == SHW'(WIDTH - 1);
    case (op)
      4'b0000: alu_y = operand_a & b;
      4'b0001: alu_y = operand_a | b;
      4'b0010: alu_y = operand_a + b;
      4'b0110: alu_y = operand_a - b;
      4'b0111: alu_y = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(b)};
      4'b1100: alu_y = ~(operand_a | b);
      4'b0011: alu_y = b << shamt;
      4'b0100: alu_y = b >> shamt;
      4'b0101: alu_y = $signed(b) >>> shamt;
      4'b1101: alu_y = hi;
      4'b1110: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, mcand} : '0);
    sh = {acc, q[WIDTH-1]};
    trial = sh - {1'b0, mcand};
    acc_n = state == DIV ? (trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0]) : sum[WIDTH:1];
    q_n = state == DIV ? {q[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], q[WIDTH-1:1]};
    {prod_hi, prod_lo} = (sign_a ^ sign_b) ? -{acc_n, q_n} : {acc_n, q_n};
    quot = div_zero ? '1 : (sign_a ^ sign_b) ? -q_n : q_n;
    rem = sign_a ? -acc_n : acc_n;
    hi_f = state == DIV ? rem : prod_hi;
    lo_f = state == DIV ? quot : prod_lo;
  end

  always_comb begin
    state_n = state == IDLE ? (start ? (md ? (op[1] ? DIV : MUL) : DONE) : IDLE) :
              state == DONE ? IDLE : last ? DONE : state;
    busy = state == MUL || state == DIV;
    done = state == DONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      acc <= '0;
      q <= '0;
      count <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div_zero <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start && md) begin
        mcand <= abs_b;
        q <= abs_a;
        acc <= '0;
        count <= '0;
        sign_a <= op[0] & operand_a[WIDTH-1];
        sign_b <= op[0] & b[WIDTH-1];
        div_zero <= b == '0;
      end else if (state == IDLE && start) begin
        result <= alu_y;
        zero <= alu_y == '0;
      end else if (busy) begin
        acc <= acc_n;
        q <= q_n;
        count <= count + 1'b1;
        if (last) begin
          hi <= hi_f;
          lo <= lo_f;
          result <= lo_f;
          zero <= lo_f == '0;
        end
      end
    end
  end
endmodule

// File: doc/execute_unit_mc.md
Name: execute_unit_mc

Overview:
- Parametrised, multicycle successor to the single-cycle execute stage.
- Contains the operand-B mux (register or immediate), a registered ALU, an iterative shift-add multiplier and a restoring divider writing HI/LO registers.
- Coordinated by a start/busy/done handshake with the control FSM.
- Sits between register-read and memory/write-back; the control FSM holds its state until done.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  4  decoded ALU control (encoding below).
- operand_a  in  WIDTH  register rs value.
- operand_b  in  WIDTH  register rt value.
- immediate  in  WIDTH  sign/zero-extended immediate.
- alu_src  in  1  1 = B is immediate, 0 = B is operand_b.
- shamt  in  SHW  shift amount.
- busy  out  1  high while mul/div iterating.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset value of every output and all internal state is 0; FSM goes to IDLE. Reset mid-operation aborts immediately; HI/LO are cleared.
- Operand capture: A = operand_a; B = alu_src ? immediate : operand_b. Both are captured on the start cycle, so later input changes are ignored.

Op encoding:
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR.
- 0011 SLL B by shamt, 0100 SRL, 0101 SRA.
- 1101 MFHI, 1110 MFLO.
- 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV.
- 1111 reserved: result 0.
- ADD/SUB wrap modulo 2^WIDTH with no overflow flag.

FSM states:
- IDLE:
  - start with a single-cycle op -> DONE; result/zero load on that edge.
  - start with a mul/div op -> MUL or DIV; load magnitudes (signed ops take the absolute value and record the signs) and count = 0.
  - No start: stay in IDLE.
- MUL: WIDTH iterations, one per cycle. If the multiplier LSB is set, add the multiplicand to the upper accumulator; shift right. busy = 1.
- DIV: WIDTH restoring iterations, one per cycle. Shift the remainder left with the next dividend bit, trial-subtract the divisor, set the quotient bit if the result is non-negative. busy = 1.
- Iteration end: after the WIDTH-th iteration -> DONE.
  - Apply sign fixes: product negated if sign_a ^ sign_b; quotient negated if sign_a ^ sign_b; remainder takes sign_a.
  - Write HI/LO: product {HI,LO}; HI = remainder, LO = quotient.
  - result = LO.
- DONE: done = 1 for exactly one cycle -> IDLE. busy = 0.

Latency:
- Single-cycle ops: done is asserted the cycle after start.
- Mul/div: done is asserted WIDTH+1 cycles after start. busy covers cycles 1..WIDTH.

Handshake:
- start is ignored in MUL, DIV and DONE; no queuing.
- A new start is accepted in the cycle after done (back-to-back throughput).

Hold rules:
- result/zero hold their value until the next completion.
- HI/LO change only at mul/div completion; MFHI/MFLO read the registered values.

Boundary cases:
- Divide by zero (either signedness): completes at normal latency with HI = dividend and LO = all ones (unsigned pattern); no exception.
- DIV MIN / -1: LO = MIN, HI = 0.
- MULT MIN * MIN: {HI,LO} = 2^(2*WIDTH-2).

Test Plan:
- Reset mid-MULT (assert reset at count 10): all outputs 0 the same cycle; IDLE next; a start two cycles later completes normally.
- ADD with alu_src = 1, operand_a = 5, immediate = 0xFFFFFFFF: done at cycle+1, result = 4, zero = 0. SUB 7-7: result = 0, zero = 1.
- SRA with B = 0x80000000, shamt = 4: result = 0xF8000000. SLT with -1, 1: result = 1.
- MULT with A = -3, B = 7: busy for 32 cycles, done at cycle+33, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, result = LO. MULTU 0xFFFFFFFF*2: HI = 1, LO = 0xFFFFFFFE.
- DIV -7/2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU by 0 of 9: HI = 9, LO = 0xFFFFFFFF.
- start pulsed during busy is ignored; a start in the cycle after done with MFHI is accepted and returns the prior HI.
